// File: rtl/infer_sched.sv
// -----------------------------------------------------------------------------
// infer_sched -- job scheduler in front of the MNIST inference control FSM.
//
// Two requesters (A: UART host loader, B: on-board test-image selector) each
// offer an image index. A round-robin arbiter grants one job. The scheduler
// then holds the core's level start until the core reports done, captures the
// predicted digit (or a timeout error) into a small first-word-fall-through
// result FIFO, and waits for done to clear before it accepts the next job.
//
// Ports:
//   clk, rst (async, active-low)
//   req_a/img_a/gnt_a    requester A: level request, image index, grant pulse
//   req_b/img_b/gnt_b    requester B: level request, image index, grant pulse
//   core_start           level start to the inference core
//   core_done/core_digit done level and argmax result from the core
//   img_sel              image index of the active job, to the image memory
//   res_valid/res_ready  result FIFO handshake (pop on valid & ready)
//   res_digit/res_img/res_src/res_err  head FIFO entry
//   sched_busy           high whenever the FSM is not idle
//   err_cnt              saturating count of timed-out jobs
//
// Optional build macro SCHED_PERF_EN adds output last_lat: the number of WAIT
// cycles of the most recent job (TIMEOUT when the job timed out).
// -----------------------------------------------------------------------------
module infer_sched #(
   parameter int IMG_AW    = 4,
   parameter int TO_W      = 12,
   parameter int TIMEOUT   = 2047,
   parameter int RES_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_a,
   input  logic [IMG_AW-1:0] img_a,
   output logic              gnt_a,
   input  logic              req_b,
   input  logic [IMG_AW-1:0] img_b,
   output logic              gnt_b,
   output logic              core_start,
   input  logic              core_done,
   input  logic [3:0]        core_digit,
   output logic [IMG_AW-1:0] img_sel,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [3:0]        res_digit,
   output logic [IMG_AW-1:0] res_img,
   output logic              res_src,
   output logic              res_err,
   output logic              sched_busy,
   output logic [7:0]        err_cnt
`ifdef SCHED_PERF_EN
   ,
   output logic [TO_W-1:0]   last_lat
`endif
);

   localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
   localparam int CNT_W = $clog2(RES_DEPTH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_CAPT,
      S_RELEASE
   } state_t;

   typedef struct packed {
      logic [3:0]        digit;
      logic [IMG_AW-1:0] img;
      logic              src;
      logic              err;
   } res_t;

   state_t            state_q, state_d;
   logic              gnt_a_q, gnt_a_d;
   logic              gnt_b_q, gnt_b_d;
   logic              core_start_q, core_start_d;
   logic [IMG_AW-1:0] img_sel_q, img_sel_d;
   logic              src_q, src_d;
   logic              last_gnt_q, last_gnt_d;   // 0 = A, 1 = B
   logic [3:0]        digit_q, digit_d;
   logic              err_q, err_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [7:0]        err_cnt_q, err_cnt_d;

   res_t              mem_q [RES_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              push, pop;
   logic              eligible, win_a, win_b;
   res_t              head;

   // A slot is reserved before the job starts, so CAPT can always push.
   assign eligible = (count_q < CNT_W'(RES_DEPTH));
   // On a tie the side that was not granted last time wins.
   assign win_a    = eligible & req_a & (~req_b | last_gnt_q);
   assign win_b    = eligible & req_b & (~req_a | ~last_gnt_q);

   // ---------------------------------------------------------------- FSM ---
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // a value unassigned and no latch is inferred.
      state_d      = state_q;
      gnt_a_d      = 1'b0;
      gnt_b_d      = 1'b0;
      core_start_d = core_start_q;
      img_sel_d    = img_sel_q;
      src_d        = src_q;
      last_gnt_d   = last_gnt_q;
      digit_d      = digit_q;
      err_d        = err_q;
      to_cnt_d     = to_cnt_q;
      err_cnt_d    = err_cnt_q;
      push         = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            core_start_d = 1'b0;
            if (win_a) begin
               gnt_a_d    = 1'b1;
               img_sel_d  = img_a;
               src_d      = 1'b0;
               last_gnt_d = 1'b0;
               state_d    = S_START;
            end else if (win_b) begin
               gnt_b_d    = 1'b1;
               img_sel_d  = img_b;
               src_d      = 1'b1;
               last_gnt_d = 1'b1;
               state_d    = S_START;
            end
         end
         S_START: begin
            core_start_d = 1'b1;
            to_cnt_d     = '0;
            state_d      = S_WAIT;
         end
         S_WAIT: begin
            // The counter counts this cycle too, so on exit it equals the
            // number of WAIT cycles spent (TIMEOUT on a timeout).
            core_start_d = 1'b1;
            to_cnt_d     = to_cnt_q + TO_W'(1);
            if (core_done) begin
               digit_d      = core_digit;
               err_d        = 1'b0;
               core_start_d = 1'b0;
               state_d      = S_CAPT;
            end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
               digit_d      = 4'hF;
               err_d        = 1'b1;
               err_cnt_d    = (err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
               core_start_d = 1'b0;
               state_d      = S_CAPT;
            end
         end
         S_CAPT: begin
            push         = 1'b1;
            core_start_d = 1'b0;
            state_d      = S_RELEASE;
         end
         S_RELEASE: begin
            core_start_d = 1'b0;
            if (!core_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         gnt_a_q      <= 1'b0;
         gnt_b_q      <= 1'b0;
         core_start_q <= 1'b0;
         img_sel_q    <= '0;
         src_q        <= 1'b0;
         last_gnt_q   <= 1'b1;
         digit_q      <= '0;
         err_q        <= 1'b0;
         to_cnt_q     <= '0;
         err_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         gnt_a_q      <= gnt_a_d;
         gnt_b_q      <= gnt_b_d;
         core_start_q <= core_start_d;
         img_sel_q    <= img_sel_d;
         src_q        <= src_d;
         last_gnt_q   <= last_gnt_d;
         digit_q      <= digit_d;
         err_q        <= err_d;
         to_cnt_q     <= to_cnt_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   // -------------------------------------------------------- result FIFO ---
   assign pop = res_valid & res_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // NOTE: the storage array is deliberately not reset; count_q alone decides
   // which entries are valid, and the head outputs are masked while empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= '{digit: digit_q, img: img_sel_q, src: src_q, err: err_q};
   end

   assign head      = mem_q[rd_ptr_q];
   assign res_valid = (count_q != '0);
   assign res_digit = res_valid ? head.digit : '0;
   assign res_img   = res_valid ? head.img   : '0;
   assign res_src   = res_valid & head.src;
   assign res_err   = res_valid & head.err;

   // ------------------------------------------------------------ outputs ---
   assign gnt_a      = gnt_a_q;
   assign gnt_b      = gnt_b_q;
   assign core_start = core_start_q;
   assign img_sel    = img_sel_q;
   assign sched_busy = (state_q != S_IDLE);
   assign err_cnt    = err_cnt_q;

`ifdef SCHED_PERF_EN
   logic [TO_W-1:0] last_lat_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  last_lat_q <= '0;
      else if (state_q == S_CAPT) last_lat_q <= to_cnt_q;
   end

   assign last_lat = last_lat_q;
`endif

endmodule

// File: tb/tb_infer_sched.sv
// -----------------------------------------------------------------------------
// tb_infer_sched -- directed bench for infer_sched.
//
// A small behavioural core model answers core_start: it raises core_done with
// core_dig after core_lat start cycles (never when core_never is set) and
// keeps done high core_hold cycles after start drops. Inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_infer_sched;

   localparam int IMG_AW = 4;
   localparam int TO_W   = 12;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_a, req_b;
   logic [IMG_AW-1:0] img_a, img_b;
   logic              gnt_a, gnt_b;
   logic              core_start;
   logic              core_done;
   logic [3:0]        core_digit;
   logic [IMG_AW-1:0] img_sel;
   logic              res_valid, res_ready;
   logic [3:0]        res_digit;
   logic [IMG_AW-1:0] res_img;
   logic              res_src, res_err;
   logic              sched_busy;
   logic [7:0]        err_cnt;
`ifdef SCHED_PERF_EN
   logic [TO_W-1:0]   last_lat;
`endif

   int total = 0;
   int bad   = 0;

   // core model controls
   int   core_lat   = 830;
   int   core_hold  = 0;
   bit   core_never = 1'b0;
   logic [3:0] core_dig = 4'd7;
   int   scnt = 0;
   int   hold_cnt = 0;

   always #5 clk = ~clk;

   infer_sched dut (
      .clk        (clk),
      .rst        (rst),
      .req_a      (req_a),
      .img_a      (img_a),
      .gnt_a      (gnt_a),
      .req_b      (req_b),
      .img_b      (img_b),
      .gnt_b      (gnt_b),
      .core_start (core_start),
      .core_done  (core_done),
      .core_digit (core_digit),
      .img_sel    (img_sel),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_digit  (res_digit),
      .res_img    (res_img),
      .res_src    (res_src),
      .res_err    (res_err),
      .sched_busy (sched_busy),
      .err_cnt    (err_cnt)
`ifdef SCHED_PERF_EN
      ,
      .last_lat   (last_lat)
`endif
   );

   // Behavioural inference core, updated on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         core_done = 1'b0;
         scnt      = 0;
         hold_cnt  = 0;
      end else if (core_start) begin
         if (!core_never && scnt == core_lat) begin
            core_done  = 1'b1;
            core_digit = core_dig;
         end
         scnt     = scnt + 1;
         hold_cnt = 0;
      end else begin
         scnt = 0;
         if (core_done) begin
            if (hold_cnt >= core_hold) core_done = 1'b0;
            else                       hold_cnt  = hold_cnt + 1;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_gnt(input string tag, output bit ga, output bit gb);
      ga = 1'b0;
      gb = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (gnt_a || gnt_b) begin
            ga = gnt_a;
            gb = gnt_b;
            return;
         end
      end
      check({tag, "_gnt_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (!sched_busy) return;
      end
      check({tag, "_idle_timeout"}, 32'd0, 32'd1);
   endtask

   // Count consecutive core_start-high samples, starting with the current one.
   task automatic count_start(output int hi);
      int n = 0;
      hi = 32'(core_start === 1'b1);
      while (core_start === 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
         if (core_start === 1'b1) hi++;
      end
   endtask

   task automatic pop_check(input string tag, input logic [3:0] dig, input logic [IMG_AW-1:0] img,
                            input logic src, input logic err);
      check({tag, "_valid"}, 32'(res_valid), 32'd1);
      check({tag, "_digit"}, 32'(res_digit), 32'(dig));
      check({tag, "_img"},   32'(res_img),   32'(img));
      check({tag, "_src"},   32'(res_src),   32'(src));
      check({tag, "_err"},   32'(res_err),   32'(err));
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      bit ga, gb;
      int hi, ng, rise_idx;
      logic exp_src [3];
      exp_src = '{1'b0, 1'b1, 1'b0};

      rst = 1'b0; req_a = 1'b0; req_b = 1'b0; img_a = '0; img_b = '0; res_ready = 1'b0;
      repeat (3) @(negedge clk);

      // ---- reset state
      check("rst_core_start", 32'(core_start), 32'd0);
      check("rst_gnt_a",      32'(gnt_a),      32'd0);
      check("rst_gnt_b",      32'(gnt_b),      32'd0);
      check("rst_res_valid",  32'(res_valid),  32'd0);
      check("rst_busy",       32'(sched_busy), 32'd0);
      check("rst_err_cnt",    32'(err_cnt),    32'd0);
      check("rst_img_sel",    32'(img_sel),    32'd0);
      check("rst_res_digit",  32'(res_digit),  32'd0);
      rst = 1'b1;
      @(negedge clk);

      // ---- single A job, done after 830 start cycles, digit 7
      req_a = 1'b1; img_a = 4'd3;
      @(negedge clk);
      check("t1_gnt_a",       32'(gnt_a),      32'd1);
      check("t1_gnt_b",       32'(gnt_b),      32'd0);
      check("t1_busy",        32'(sched_busy), 32'd1);
      check("t1_start_early", 32'(core_start), 32'd0);
      req_a = 1'b0;
      @(negedge clk);
      check("t1_gnt_pulse",   32'(gnt_a),      32'd0);
      check("t1_start_rise",  32'(core_start), 32'd1);
      check("t1_img_sel",     32'(img_sel),    32'd3);
      count_start(hi);
      check("t1_start_len",   32'(hi),         32'd831);
      check("t1_valid_early", 32'(res_valid),  32'd0);
      @(negedge clk);
`ifdef SCHED_PERF_EN
      check("t1_last_lat",    32'(last_lat),   32'd831);
`endif
      pop_check("t1_res", 4'd7, 4'd3, 1'b0, 1'b0);
      check("t1_err_cnt",     32'(err_cnt),    32'd0);
      wait_idle("t1");
      check("t1_empty",       32'(res_valid),  32'd0);

      // ---- both requesting for three jobs: A, B, A
      do_reset();
      core_lat = 5; core_dig = 4'd1;
      req_a = 1'b1; req_b = 1'b1; img_a = 4'd1; img_b = 4'd2;
      for (int j = 0; j < 3; j++) begin
         wait_gnt("t2", ga, gb);
         check("t2_gnt_a", 32'(ga), 32'(!exp_src[j]));
         check("t2_gnt_b", 32'(gb), 32'(exp_src[j]));
      end
      req_a = 1'b0; req_b = 1'b0;
      wait_idle("t2");
      pop_check("t2_r0", 4'd1, 4'd1, 1'b0, 1'b0);
      pop_check("t2_r1", 4'd1, 4'd2, 1'b1, 1'b0);
      pop_check("t2_r2", 4'd1, 4'd1, 1'b0, 1'b0);

      // ---- core never answers: timeout after 2047 WAIT cycles
      core_never = 1'b1;
      req_a = 1'b1; img_a = 4'd5;
      wait_gnt("t3", ga, gb);
      check("t3_gnt_a", 32'(ga), 32'd1);
      req_a = 1'b0;
      @(negedge clk);
      count_start(hi);
      check("t3_start_len", 32'(hi), 32'd2047);
      wait_idle("t3");
      check("t3_err_cnt", 32'(err_cnt), 32'd1);
`ifdef SCHED_PERF_EN
      check("t3_last_lat", 32'(last_lat), 32'd2047);
`endif
      pop_check("t3_res", 4'hF, 4'd5, 1'b0, 1'b1);
      core_never = 1'b0; core_lat = 5; core_dig = 4'd4;
      req_b = 1'b1; img_b = 4'd9;
      wait_gnt("t3b", ga, gb);
      check("t3b_gnt_b", 32'(gb), 32'd1);
      req_b = 1'b0;
      wait_idle("t3b");
      pop_check("t3b_res", 4'd4, 4'd9, 1'b1, 1'b0);
      check("t3b_err_cnt", 32'(err_cnt), 32'd1);

      // ---- FIFO full: only four jobs accepted until a pop
      core_lat = 3; core_dig = 4'd2;
      req_a = 1'b1; img_a = 4'd6;
      ng = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (gnt_a === 1'b1) ng++;
      end
      check("t4_grants",  32'(ng),         32'd4);
      check("t4_blocked", 32'(sched_busy), 32'd0);
      pop_check("t4_pop0", 4'd2, 4'd6, 1'b0, 1'b0);
      wait_gnt("t4", ga, gb);
      check("t4_gnt5", 32'(ga), 32'd1);
      req_a = 1'b0;
      wait_idle("t4");
      for (int i = 0; i < 4; i++) pop_check("t4_drain", 4'd2, 4'd6, 1'b0, 1'b0);
      check("t4_empty", 32'(res_valid), 32'd0);

      // ---- core holds done 10 cycles after start drops
      core_lat = 4; core_hold = 10; core_dig = 4'd8;
      req_a = 1'b1; img_a = 4'd4;
      wait_gnt("t5", ga, gb);
      check("t5_gnt_a", 32'(ga), 32'd1);
      for (int i = 0; i < 50 && core_start !== 1'b1; i++) @(negedge clk);
      for (int i = 0; i < 100 && core_start === 1'b1; i++) @(negedge clk);
      check("t5_start_fell", 32'(core_start), 32'd0);
      rise_idx = -1;
      for (int i = 0; i < 20; i++) begin
         if (i <= 10) check("t5_busy", 32'(sched_busy), 32'd1);
         if (core_start === 1'b1 && rise_idx < 0) rise_idx = i;
         @(negedge clk);
      end
      check("t5_restart_idx", 32'(rise_idx), 32'd13);
      req_a = 1'b0;
      wait_idle("t5");
      pop_check("t5_r0", 4'd8, 4'd4, 1'b0, 1'b0);
      core_hold = 0;

      // ---- reset in the middle of WAIT, one entry still queued
      core_lat = 830;
      req_a = 1'b1; img_a = 4'd7;
      wait_gnt("t6", ga, gb);
      req_a = 1'b0;
      repeat (5) @(negedge clk);
      check("t6_pre_start", 32'(core_start), 32'd1);
      check("t6_pre_valid", 32'(res_valid),  32'd1);
      rst = 1'b0;
      #1;
      check("t6_rst_start",   32'(core_start), 32'd0);
      check("t6_rst_valid",   32'(res_valid),  32'd0);
      check("t6_rst_err_cnt", 32'(err_cnt),    32'd0);
      check("t6_rst_busy",    32'(sched_busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      core_lat = 5; core_dig = 4'd5;
      req_a = 1'b1; req_b = 1'b1; img_a = 4'd2; img_b = 4'd3;
      wait_gnt("t6", ga, gb);
      check("t6_first_a", 32'(ga), 32'd1);
      check("t6_first_b", 32'(gb), 32'd0);
      req_a = 1'b0; req_b = 1'b0;
      wait_idle("t6");
      pop_check("t6_res", 4'd5, 4'd2, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
